norm2_sq_window: RTL and testbench

Cross-channel sum-of-squares window for the norm2 LRN stage. Sits directly upstream of the norm2 alpha-scaling multiplier, which takes a 44-bit unsigned sum and a 6-bit unsigned coefficient.
For each pixel, takes a channel-ordered stream of signed activations. For each output channel c, produces the sum of x[c-HALF..c+HALF]^2 as a 44-bit unsigned value, with zero padding at channel edges. Also forwards the centre activation x[c] for the downstream divide stage.

---
 rtl/norm2_pkg.sv | 16 +
 rtl/norm2_square_unit.sv | 17 +
 rtl/norm2_sq_window.sv | 175 +++++++++++++++++
 tb/tb_norm2_sq_window.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/norm2_pkg.sv
// Shared parameters and types for the norm2 cross-channel sum-of-squares window.
package norm2_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned SUM_W    = 44;
  localparam int unsigned NUM_CH   = 256;
  localparam int unsigned LRN_SIZE = 5;
  localparam int unsigned HALF     = (LRN_SIZE - 1) / 2;
  localparam int unsigned SQ_W     = 2 * DATA_W;

  typedef enum logic {
    ACCEPT = 1'b0,
    FLUSH  = 1'b1
  } state_e;

endpackage

// File: rtl/norm2_square_unit.sv
// Combinational signed square of one activation; the result is always non-negative.
module norm2_square_unit
  import norm2_pkg::*;
(
  input  logic [DATA_W-1:0] din,
  output logic [SQ_W-1:0]   dout_c
);

  logic signed [SQ_W-1:0] din_ext;

  // Sign-extend to full product width, then square; (-2^(W-1))^2 still fits.
  always_comb begin
    din_ext = SQ_W'($signed(din));
    dout_c  = SQ_W'(din_ext * din_ext);
  end

endmodule

// File: rtl/norm2_sq_window.sv
// Sliding LRN window: per output channel, sum of squares over channels c-HALF..c+HALF
// with zero padding at the pixel edges, plus the centre activation for the divide stage.
module norm2_sq_window
  import norm2_pkg::*;
#(
  parameter int unsigned N_CH = NUM_CH
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [SUM_W-1:0]  out_sum,
  output logic [DATA_W-1:0] out_center,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned CNT_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned FL_W  = (HALF > 0) ? $clog2(HALF + 1) : 1;

  // Elaboration-time sanity on window geometry and sum headroom.
  if ((LRN_SIZE % 2) == 0 || LRN_SIZE < 3) begin : g_bad_lrn_size
    $error("norm2_sq_window: LRN_SIZE must be odd and at least 3");
  end
  if (SUM_W < $clog2(LRN_SIZE + 1) + 2 * DATA_W - 2) begin : g_bad_sum_w
    $error("norm2_sq_window: SUM_W too narrow for LRN_SIZE*2^(2*DATA_W-2)");
  end
  if (N_CH <= HALF) begin : g_bad_num_ch
    $error("norm2_sq_window: N_CH must exceed HALF");
  end

  state_e              state_q,      state_d;
  logic [CNT_W-1:0]    ch_cnt_q,     ch_cnt_d;
  logic [FL_W-1:0]     flush_cnt_q,  flush_cnt_d;
  logic [SQ_W-1:0]     sq_q   [LRN_SIZE];
  logic [SQ_W-1:0]     sq_d   [LRN_SIZE];
  logic [DATA_W-1:0]   ctr_q  [HALF+1];
  logic [DATA_W-1:0]   ctr_d  [HALF+1];
  logic [SUM_W-1:0]    sum_q,        sum_d;
  logic [SUM_W-1:0]    out_sum_q,    out_sum_d;
  logic [DATA_W-1:0]   out_center_q, out_center_d;
  logic                out_last_q,   out_last_d;
  logic                out_valid_q,  out_valid_d;

  logic [SQ_W-1:0]     sq_in_c;
  logic                can_adv;
  logic                step;
  logic                load;
  logic                last_step;
  logic                clear;
  logic [SQ_W-1:0]     sq_new;
  logic [DATA_W-1:0]   ctr_new;
  logic [SUM_W-1:0]    sum_upd;

  norm2_square_unit u_square (
    .din    (in_data),
    .dout_c (sq_in_c)
  );

  // Next-state: FSM, shift step, running sum update and output register load.
  always_comb begin
    state_d      = state_q;
    ch_cnt_d     = ch_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    sq_d         = sq_q;
    ctr_d        = ctr_q;
    sum_d        = sum_q;
    out_sum_d    = out_sum_q;
    out_center_d = out_center_q;
    out_last_d   = out_last_q;
    out_valid_d  = out_valid_q;
    step         = 1'b0;
    load         = 1'b0;
    last_step    = 1'b0;
    clear        = 1'b0;
    sq_new       = '0;
    ctr_new      = '0;
    sum_upd      = sum_q;

    can_adv  = !out_valid_q || out_ready;
    in_ready = can_adv && (state_q == ACCEPT);

    unique case (state_q)
      ACCEPT: begin
        if (in_valid && in_ready) begin
          step    = 1'b1;
          sq_new  = sq_in_c;
          ctr_new = in_data;
          load    = (ch_cnt_q >= CNT_W'(HALF));
          if (ch_cnt_q == CNT_W'(N_CH - 1)) begin
            state_d     = FLUSH;
            flush_cnt_d = '0;
          end else begin
            ch_cnt_d = ch_cnt_q + CNT_W'(1);
          end
        end
      end
      FLUSH: begin
        if (can_adv) begin
          step = 1'b1;
          load = 1'b1;
          if (flush_cnt_q == FL_W'(HALF - 1)) begin
            last_step = 1'b1;
            clear     = 1'b1;
            state_d   = ACCEPT;
          end else begin
            flush_cnt_d = flush_cnt_q + FL_W'(1);
          end
        end
      end
      default: state_d = ACCEPT;
    endcase

    if (step) begin
      sum_upd  = sum_q + SUM_W'(sq_new) - SUM_W'(sq_q[LRN_SIZE-1]);
      sum_d    = sum_upd;
      sq_d[0]  = sq_new;
      for (int i = 1; i < int'(LRN_SIZE); i++) sq_d[i] = sq_q[i-1];
      ctr_d[0] = ctr_new;
      for (int i = 1; i <= int'(HALF); i++) ctr_d[i] = ctr_q[i-1];
      if (load) begin
        out_valid_d  = 1'b1;
        out_sum_d    = sum_upd;
        out_center_d = ctr_d[HALF];
        out_last_d   = last_step;
      end
    end

    if (!(step && load) && out_ready) out_valid_d = 1'b0;

    // End of pixel: start the next one from an empty window.
    if (clear) begin
      for (int i = 0; i < int'(LRN_SIZE); i++) sq_d[i] = '0;
      for (int i = 0; i <= int'(HALF); i++) ctr_d[i] = '0;
      sum_d       = '0;
      ch_cnt_d    = '0;
      flush_cnt_d = '0;
    end
  end

  // State, delay lines, running sum and output registers.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q      <= ACCEPT;
      ch_cnt_q     <= '0;
      flush_cnt_q  <= '0;
      for (int i = 0; i < int'(LRN_SIZE); i++) sq_q[i] <= '0;
      for (int i = 0; i <= int'(HALF); i++) ctr_q[i] <= '0;
      sum_q        <= '0;
      out_sum_q    <= '0;
      out_center_q <= '0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_cnt_q     <= ch_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      sq_q         <= sq_d;
      ctr_q        <= ctr_d;
      sum_q        <= sum_d;
      out_sum_q    <= out_sum_d;
      out_center_q <= out_center_d;
      out_last_q   <= out_last_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign out_sum    = out_sum_q;
  assign out_center = out_center_q;
  assign out_last   = out_last_q;
  assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_norm2_sq_window.sv
// Directed bench for norm2_sq_window with an 8-channel pixel.
module tb_norm2_sq_window;

  localparam int unsigned NCH = 8;

  localparam logic [43:0] EXP_RAMP [8] = '{44'd14, 44'd30, 44'd55, 44'd90,
                                           44'd135, 44'd190, 44'd174, 44'd149};
  localparam logic [43:0] EXP_MIN  [8] = '{44'd3221225472, 44'd4294967296,
                                           44'd5368709120, 44'd5368709120,
                                           44'd5368709120, 44'd5368709120,
                                           44'd4294967296, 44'd3221225472};

  logic        ap_clk;
  logic        ap_rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [43:0] out_sum;
  logic [15:0] out_center;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  int tests;
  int fails;

  logic [15:0] in_q     [$];
  logic [43:0] got_sum  [$];
  logic [15:0] got_ctr  [$];
  logic        got_last [$];
  int          flush_gap;

  norm2_sq_window #(.N_CH(NCH)) dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_sum    (out_sum),
    .out_center (out_center),
    .out_last   (out_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Drive in_q into the DUT and collect n_out transfers; rdy_mode 1 toggles out_ready
  // 1,0,0,1; gap_mode 1 inserts random idle cycles between words.
  task automatic run(input int n_out, input int rdy_mode, input int gap_mode);
    int idx = 0;
    int cyc = 0;
    int phase = 0;
    int low_run = 0;
    bit counting = 0;
    bit pending = 0;
    got_sum.delete();
    got_ctr.delete();
    got_last.delete();
    flush_gap = -1;
    while ((idx < in_q.size() || got_sum.size() < n_out) && cyc < 400) begin
      @(posedge ap_clk);
      #1;
      out_ready = (rdy_mode == 0) ? 1'b1 : ((phase % 4) == 0 || (phase % 4) == 3);
      phase++;
      if (!pending) begin
        if (idx < in_q.size() && !(gap_mode != 0 && $urandom_range(0, 2) == 0)) begin
          in_valid = 1'b1;
          in_data  = in_q[idx];
        end else begin
          in_valid = 1'b0;
          in_data  = '0;
        end
      end
      @(negedge ap_clk);
      if (rdy_mode != 0 && out_valid && !out_ready) begin
        tests++;
        if (in_ready !== 1'b0) begin
          fails++;
          $display("FAIL stall_in_ready cyc=%0d: got %b want 0", cyc, in_ready);
        end
      end
      if (counting) begin
        if (!in_ready) low_run++;
        else begin
          flush_gap = low_run;
          counting  = 0;
        end
      end
      if (out_valid && out_ready) begin
        got_sum.push_back(out_sum);
        got_ctr.push_back(out_center);
        got_last.push_back(out_last);
      end
      if (in_valid && in_ready) begin
        idx++;
        pending = 0;
        if ((idx % NCH) == 0) begin
          counting = 1;
          low_run  = 0;
        end
      end else begin
        pending = in_valid;
      end
      cyc++;
    end
    if (cyc >= 400) begin
      tests++;
      fails++;
      $display("FAIL run_timeout: got %0d outputs want %0d", got_sum.size(), n_out);
    end
    @(posedge ap_clk);
    #1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
  endtask

  task automatic load_ramp();
    in_q.delete();
    for (int i = 1; i <= 8; i++) in_q.push_back(16'(i));
  endtask

  task automatic test_reset();
    ap_rst    = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    tests++;
    if (out_valid !== 1'b0 || out_sum !== 44'd0 || out_center !== 16'd0 ||
        out_last !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset: got v=%b s=%0d c=%0d l=%b r=%b want 0 0 0 0 1",
               out_valid, out_sum, out_center, out_last, in_ready);
    end
    ap_rst = 1'b0;
  endtask

  task automatic test_ramp(input string name, input int rdy_mode, input int gap_mode,
                           input bit chk_gap);
    load_ramp();
    run(8, rdy_mode, gap_mode);
    tests++;
    if (got_sum.size() != 8) begin
      fails++;
      $display("FAIL %s_count: got %0d want 8", name, got_sum.size());
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (got_sum[i] !== EXP_RAMP[i] || got_ctr[i] !== 16'(i + 1) || got_last[i] !== (i == 7)) begin
        fails++;
        $display("FAIL %s[%0d]: got sum=%0d ctr=%0d last=%b want sum=%0d ctr=%0d last=%b",
                 name, i, got_sum[i], got_ctr[i], got_last[i], EXP_RAMP[i], i + 1, (i == 7));
      end
    end
    if (chk_gap) begin
      tests++;
      if (flush_gap != 2) begin
        fails++;
        $display("FAIL %s_flush_gap: got %0d want 2", name, flush_gap);
      end
    end
    @(negedge ap_clk);
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle_valid: got %b want 0", name, out_valid);
    end
  endtask

  task automatic test_min_value();
    in_q.delete();
    for (int i = 0; i < 8; i++) in_q.push_back(16'h8000);
    run(8, 0, 0);
    tests++;
    if (got_sum.size() != 8) begin
      fails++;
      $display("FAIL min_count: got %0d want 8", got_sum.size());
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (got_sum[i] !== EXP_MIN[i] || got_ctr[i] !== 16'h8000 || got_last[i] !== (i == 7)) begin
        fails++;
        $display("FAIL min[%0d]: got sum=%0d ctr=%h last=%b want sum=%0d ctr=8000 last=%b",
                 i, got_sum[i], got_ctr[i], got_last[i], EXP_MIN[i], (i == 7));
      end
    end
  endtask

  task automatic test_back_to_back();
    load_ramp();
    for (int i = 0; i < 8; i++) in_q.push_back(16'd0);
    run(16, 0, 0);
    tests++;
    if (got_sum.size() != 16) begin
      fails++;
      $display("FAIL b2b_count: got %0d want 16", got_sum.size());
    end
    for (int i = 0; i < 16; i++) begin
      logic [43:0] es;
      logic [15:0] ec;
      es = (i < 8) ? EXP_RAMP[i % 8] : 44'd0;
      ec = (i < 8) ? 16'(i + 1) : 16'd0;
      tests++;
      if (got_sum[i] !== es || got_ctr[i] !== ec || got_last[i] !== (i == 7 || i == 15)) begin
        fails++;
        $display("FAIL b2b[%0d]: got sum=%0d ctr=%0d last=%b want sum=%0d ctr=%0d last=%b",
                 i, got_sum[i], got_ctr[i], got_last[i], es, ec, (i == 7 || i == 15));
      end
    end
  endtask

  task automatic test_reset_mid();
    in_q.delete();
    for (int i = 1; i <= 5; i++) in_q.push_back(16'(i));
    run(0, 0, 0);
    tests++;
    if (out_valid !== 1'b1 || out_sum !== 44'd55 || out_center !== 16'd3) begin
      fails++;
      $display("FAIL mid_pre_reset: got v=%b s=%0d c=%0d want 1 55 3",
               out_valid, out_sum, out_center);
    end
    ap_rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_sum !== 44'd0 || out_center !== 16'd0 ||
        out_last !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_async_reset: got v=%b s=%0d c=%0d l=%b r=%b want 0 0 0 0 1",
               out_valid, out_sum, out_center, out_last, in_ready);
    end
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    test_ramp("after_reset", 0, 0, 1'b1);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_ramp("ramp", 0, 0, 1'b1);
    test_min_value();
    test_ramp("backpressure", 1, 0, 1'b0);
    test_back_to_back();
    test_reset_mid();
    test_ramp("gaps", 0, 1, 1'b0);
    test_ramp("gaps_bp", 1, 1, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
